// File: rtl/tecmo_pkg.sv
// Shared types for the ROM download path: word/lane sizes, the SDRAM write word and the writer FSM states.
package tecmo_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int BYTE_LANES = 4;

  typedef struct packed {
    logic [22:0] addr;
    logic [31:0] data;
  } sdram_word_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } writer_state_t;

endpackage

// File: rtl/rom_download_writer_if.sv
// HPS ioctl byte stream plus SDRAM req/ack write port; master = HPS/SDRAM side, slave = writer.
interface rom_download_writer_if;

  logic        ioctl_download;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        ioctl_wait;

  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we;
  logic        sdram_req;
  logic        sdram_ack;

  modport master (
    output ioctl_download, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
    input  ioctl_wait, sdram_addr, sdram_data, sdram_we, sdram_req
  );

  modport slave (
    input  ioctl_download, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
    output ioctl_wait, sdram_addr, sdram_data, sdram_we, sdram_req
  );

endinterface

// File: rtl/rom_download_writer_word_fifo.sv
// word_fifo: synchronous FIFO of sdram_word_t, combinational head and next-head, push/pop in 1 cycle.
// Push into a full FIFO or pop from an empty one is ignored; the caller gates on o_full/o_empty.
module word_fifo
  import tecmo_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_push,
  input  sdram_word_t i_data,
  input  logic        i_pop,
  output sdram_word_t o_head,
  output sdram_word_t o_head_next,
  output logic [CW-1:0] o_count,
  output logic        o_empty,
  output logic        o_full
);

  sdram_word_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_count     = r_count;
  assign o_head      = r_mem[r_rd];
  assign o_head_next = r_mem[r_rd + AW'(1)];
  assign w_push_ok   = i_push & ~o_full;
  assign w_pop_ok    = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop_ok) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

endmodule

// File: rtl/rom_download_writer.sv
// Packs HPS ioctl bytes into 32-bit SDRAM writes; strobe-to-req 2 cycles, ioctl_wait at FIFO_DEPTH-1 words.
// Optional running byte checksum port with `define ROM_DOWNLOAD_CHECKSUM_EN.
module rom_download_writer
  import tecmo_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  rom_download_writer_if.slave bus,
  output logic busy,
  output logic done
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_REQ  = REQ;

  logic [0:0]            r_state;
  logic [WORD_WIDTH-1:0] r_word;
  logic [22:0]           r_waddr;
  logic [BYTE_LANES-1:0] r_mask;
  logic                  r_dl_q;
  logic                  r_dl_seen;
  logic                  r_wait;
  logic                  r_req;
  logic [22:0]           r_addr;
  logic [31:0]           r_data;
  logic                  r_done;

  logic                  w_wr;
  logic [22:0]           w_new_waddr;
  logic [1:0]            w_lane;
  logic                  w_any;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_done_cond;
  logic [WORD_WIDTH-1:0] w_word_nxt;
  logic [BYTE_LANES-1:0] w_mask_nxt;
  logic [22:0]           w_waddr_nxt;
  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  w_empty;
  logic                  w_full;
  sdram_word_t           w_head;
  sdram_word_t           w_head_next;
  sdram_word_t           w_push_word;

  assign w_wr        = bus.ioctl_wr & bus.ioctl_download;
  assign w_new_waddr = bus.ioctl_addr[24:2];
  assign w_lane      = bus.ioctl_addr[1:0];
  assign w_any       = |r_mask;

  // Push on a full word, on a strobe to another word, or while download has been low (flush).
  assign w_push_req  = (&r_mask) | (w_wr & w_any & (w_new_waddr != r_waddr)) | (~r_dl_q & w_any);
  assign w_push      = w_push_req & ~w_full;
  assign w_accept    = w_wr & ~(w_push_req & w_full);
  assign w_pop       = (r_state == ST_REQ) & bus.sdram_ack;
  assign w_push_word = '{addr: r_waddr, data: r_word};
  assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_word_nxt  = w_push ? '0 : r_word;
    w_mask_nxt  = w_push ? '0 : r_mask;
    w_waddr_nxt = r_waddr;
    if (w_accept) begin
      w_word_nxt[{w_lane, 3'b000} +: 8] = bus.ioctl_data;
      w_mask_nxt[w_lane]                = 1'b1;
      w_waddr_nxt                       = w_new_waddr;
    end
  end

  word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_data      (w_push_word),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_head_next (w_head_next),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  assign w_done_cond = ~bus.ioctl_download & ~w_any & w_empty & (r_state == ST_IDLE) & r_dl_seen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word    <= '0;
      r_waddr   <= '0;
      r_mask    <= '0;
      r_dl_q    <= 1'b0;
      r_dl_seen <= 1'b0;
      r_wait    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_word    <= w_word_nxt;
      r_waddr   <= w_waddr_nxt;
      r_mask    <= w_mask_nxt;
      r_dl_q    <= bus.ioctl_download;
      r_wait    <= (w_count_nxt >= CW'(FIFO_DEPTH - 1));
      r_done    <= w_done_cond;
      if (bus.ioctl_download) r_dl_seen <= 1'b1;
      else if (w_done_cond)   r_dl_seen <= 1'b0;
    end
  end

  // The head stays in the FIFO until acked, so it counts against ioctl_wait while in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_addr  <= w_head.addr;
            r_data  <= w_head.data;
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.sdram_ack) begin
            if (w_count >= CW'(2)) begin
              r_addr <= w_head_next.addr;
              r_data <= w_head_next.data;
            end else begin
              r_req   <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ioctl_wait = r_wait;
  assign bus.sdram_addr = r_addr;
  assign bus.sdram_data = r_data;
  assign bus.sdram_req  = r_req;
  assign bus.sdram_we   = r_req;
  assign busy           = w_any | ~w_empty | r_req;
  assign done           = r_done;

`ifdef ROM_DOWNLOAD_CHECKSUM_EN
  logic [31:0] r_cksum;
  logic        r_frozen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cksum  <= '0;
      r_frozen <= 1'b0;
    end else if (bus.ioctl_download & ~r_dl_q) begin
      r_cksum  <= w_accept ? {24'h0, bus.ioctl_data} : 32'h0;
      r_frozen <= 1'b0;
    end else begin
      if (w_accept & ~r_frozen) r_cksum <= r_cksum + {24'h0, bus.ioctl_data};
      if (w_done_cond)          r_frozen <= 1'b1;
    end
  end

  assign checksum = r_cksum;
`endif

endmodule

// File: tb/tb_rom_download_writer.sv
// Randomised bench for rom_download_writer with a byte-to-word reference model and an SDRAM ack responder.
module tb_rom_download_writer;
  import tecmo_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  logic done;
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  rom_download_writer_if bus ();

  rom_download_writer #(.FIFO_DEPTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  sdram_word_t obs_q[$];
  sdram_word_t exp_q[$];
  logic [22:0] m_waddr;
  logic [31:0] m_data;
  logic [3:0]  m_mask;

  bit stall = 1'b0;
  int ack_pct = 100;
  int done_cnt = 0;
  logic [31:0] done_cksum = '0;
  bit wait_seen = 1'b0;
  int stab_err = 0;
  int we_err = 0;

  // SDRAM side: one-cycle ack pulses, optionally throttled or stalled.
  initial begin
    bus.sdram_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n || bus.sdram_ack) bus.sdram_ack = 1'b0;
      else if (bus.sdram_req && !stall && ($urandom_range(99) < ack_pct)) bus.sdram_ack = 1'b1;
    end
  end

  initial begin
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [22:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.sdram_req && bus.sdram_ack) obs_q.push_back('{addr: bus.sdram_addr, data: bus.sdram_data});
        if (done) begin
          done_cnt++;
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
          done_cksum = checksum;
`endif
        end
        if (bus.ioctl_wait) wait_seen = 1'b1;
        if (bus.sdram_we !== bus.sdram_req) we_err++;
        if (prev_req && !prev_ack && bus.sdram_req &&
            (bus.sdram_addr !== prev_addr || bus.sdram_data !== prev_data)) stab_err++;
        prev_req  = bus.sdram_req;
        prev_ack  = bus.sdram_ack;
        prev_addr = bus.sdram_addr;
        prev_data = bus.sdram_data;
      end else begin
        prev_req = 1'b0;
        prev_ack = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: a word is the run of bytes sharing one word address, closed when all four
  // lanes are filled, when the address moves to another word, or when the download ends.
  task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
    if (m_mask != 0 && a[24:2] != m_waddr) begin
      exp_q.push_back('{addr: m_waddr, data: m_data});
      m_mask = 0;
    end
    if (m_mask == 0) begin
      m_waddr = a[24:2];
      m_data  = 0;
    end
    m_data[a[1:0]*8 +: 8] = d;
    m_mask[a[1:0]] = 1'b1;
    if (m_mask == 4'hF) begin
      exp_q.push_back('{addr: m_waddr, data: m_data});
      m_mask = 0;
    end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, output bit ok);
    int guard = 0;
    while (bus.ioctl_wait && guard < 500) begin
      tick();
      guard++;
    end
    if (bus.ioctl_wait) begin
      ok = 1'b0;
    end else begin
      bus.ioctl_addr = a;
      bus.ioctl_data = d;
      bus.ioctl_wr   = 1'b1;
      tick();
      bus.ioctl_wr   = 1'b0;
      model_byte(a, d);
      ok = 1'b1;
    end
  endtask

  task automatic end_download();
    bus.ioctl_download = 1'b0;
    if (m_mask != 0) exp_q.push_back('{addr: m_waddr, data: m_data});
    m_mask = 0;
  endtask

  task automatic wait_done(input int start, output bit ok);
    int guard = 0;
    while (done_cnt == start && guard < 2000) begin
      tick();
      guard++;
    end
    ok = (done_cnt != start);
    tick(5);
  endtask

  task automatic start_test();
    obs_q.delete();
    exp_q.delete();
    m_mask = 0;
    stab_err = 0;
    wait_seen = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.sdram_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", bus.sdram_req); end
    checks++; if (bus.sdram_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", bus.sdram_we); end
    checks++; if (bus.sdram_addr !== 23'h0 || bus.sdram_data !== 32'h0) begin errors++; $display("FAIL reset_addr_data got=%h/%h want=0/0", bus.sdram_addr, bus.sdram_data); end
    checks++; if (bus.ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait got=%b want=0", bus.ioctl_wait); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b/%b want=0/0", busy, done); end
  endtask

  task automatic test_sequential();
    bit ok;
    int start = done_cnt;
    start_test();
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send_byte(25'(i), 8'(i + 1), ok);
    end_download();
    wait_done(start, ok);
    checks++; if (!ok) begin errors++; $display("FAIL seq_done_timeout got=none want=pulse"); end
    checks++; if (done_cnt - start != 1) begin errors++; $display("FAIL seq_done_count got=%0d want=1", done_cnt - start); end
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL seq_count got=%0d want=2", obs_q.size()); end
    else begin
      checks++; if (obs_q[0] !== {23'd0, 32'h04030201}) begin errors++; $display("FAIL seq_word0 got=%h want=%h", obs_q[0], {23'd0, 32'h04030201}); end
      checks++; if (obs_q[1] !== {23'd1, 32'h08070605}) begin errors++; $display("FAIL seq_word1 got=%h want=%h", obs_q[1], {23'd1, 32'h08070605}); end
    end
  endtask

  task automatic test_partial();
    bit ok;
    int start = done_cnt;
    start_test();
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) send_byte(25'h100 + 25'(i), 8'hAA + 8'(i), ok);
    end_download();
    wait_done(start, ok);
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL partial_count got=%0d want=2", obs_q.size()); end
    else begin
      checks++; if (obs_q[0] !== {23'h40, 32'hADACABAA}) begin errors++; $display("FAIL partial_word0 got=%h want=%h", obs_q[0], {23'h40, 32'hADACABAA}); end
      checks++; if (obs_q[1] !== {23'h41, 32'h0000AFAE}) begin errors++; $display("FAIL partial_flush got=%h want=%h", obs_q[1], {23'h41, 32'h0000AFAE}); end
    end
    checks++; if (done_cnt - start != 1) begin errors++; $display("FAIL partial_done got=%0d want=1", done_cnt - start); end
  endtask

  task automatic test_stall();
    bit ok;
    int start = done_cnt;
    logic [24:0] base = 25'($urandom_range(0, 1000)) << 2;
    start_test();
    stall = 1'b1;
    bus.ioctl_download = 1'b1;
    tick();
    fork
      begin
        bit sok;
        for (int i = 0; i < 16; i++) send_byte(base + 25'(i), 8'($urandom), sok);
      end
      begin
        tick(50);
        checks++; if (bus.ioctl_wait !== 1'b1 || bus.sdram_req !== 1'b1) begin errors++; $display("FAIL stall_wait_req got=%b/%b want=1/1", bus.ioctl_wait, bus.sdram_req); end
        stall = 1'b0;
      end
    join
    end_download();
    wait_done(start, ok);
    checks++; if (!wait_seen) begin errors++; $display("FAIL stall_wait_seen got=0 want=1"); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL stall_stability got=%0d want=0", stab_err); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_word%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_jump();
    bit ok;
    int start = done_cnt;
    logic [7:0] b0 = 8'($urandom);
    logic [7:0] b1 = 8'($urandom);
    logic [7:0] b2 = 8'($urandom);
    start_test();
    bus.ioctl_download = 1'b1;
    tick();
    send_byte(25'h10, b0, ok);
    send_byte(25'h11, b1, ok);
    send_byte(25'h20, b2, ok);
    end_download();
    wait_done(start, ok);
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL jump_count got=%0d want=2", obs_q.size()); end
    else begin
      checks++; if (obs_q[0] !== {23'h4, 16'h0, b1, b0}) begin errors++; $display("FAIL jump_word4 got=%h want=%h", obs_q[0], {23'h4, 16'h0, b1, b0}); end
      checks++; if (obs_q[1] !== {23'h8, 24'h0, b2}) begin errors++; $display("FAIL jump_word8 got=%h want=%h", obs_q[1], {23'h8, 24'h0, b2}); end
    end
  endtask

  task automatic test_random();
    bit ok;
    ack_pct = 40;
    for (int d = 0; d < 3; d++) begin
      int start = done_cnt;
      logic [24:0] a = 25'($urandom);
      int n = $urandom_range(5, 20);
      start_test();
      bus.ioctl_download = 1'b1;
      tick();
      for (int i = 0; i < n; i++) begin
        send_byte(a, 8'($urandom), ok);
        a = ($urandom_range(99) < 20) ? 25'($urandom) : a + 25'd1;
      end
      end_download();
      wait_done(start, ok);
      checks++; if (done_cnt - start != 1) begin errors++; $display("FAIL rand%0d_done got=%0d want=1", d, done_cnt - start); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count got=%0d want=%0d", d, obs_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_word%0d got=%h want=%h", d, i, obs_q[i], exp_q[i]); end
      end
    end
    ack_pct = 100;
  endtask

  task automatic test_empty_download();
    bit ok;
    int start = done_cnt;
    start_test();
    bus.ioctl_download = 1'b1;
    tick(3);
    end_download();
    wait_done(start, ok);
    checks++; if (done_cnt - start != 1) begin errors++; $display("FAIL empty_done got=%0d want=1", done_cnt - start); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL empty_writes got=%0d want=0", obs_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int guard = 0;
    int start;
    start_test();
    stall = 1'b1;
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_byte(25'h40 + 25'(i), 8'($urandom), ok);
    while (!bus.sdram_req && guard < 20) begin tick(); guard++; end
    checks++; if (bus.sdram_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_before got=%b want=1", bus.sdram_req); end
    #2 reset_n = 1'b0;
    bus.ioctl_download = 1'b0;
    #1;
    checks++; if (bus.sdram_req !== 1'b0 || bus.sdram_we !== 1'b0) begin errors++; $display("FAIL rstmid_req got=%b/%b want=0/0", bus.sdram_req, bus.sdram_we); end
    checks++; if (bus.sdram_addr !== 23'h0 || bus.sdram_data !== 32'h0) begin errors++; $display("FAIL rstmid_addr_data got=%h/%h want=0/0", bus.sdram_addr, bus.sdram_data); end
    checks++; if (bus.ioctl_wait !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_flags got=%b/%b/%b want=0/0/0", bus.ioctl_wait, busy, done); end
    stall = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick();
    start = done_cnt;
    start_test();
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_byte(25'h200 + 25'(i), 8'h10 + 8'(i), ok);
    end_download();
    wait_done(start, ok);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== {23'h80, 32'h13121110}) begin errors++; $display("FAIL rstmid_after got=%0d/%h want=1/%h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, {23'h80, 32'h13121110}); end
  endtask

`ifdef ROM_DOWNLOAD_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    int start = done_cnt;
    start_test();
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_byte(25'(i), 8'hFF, ok);
    send_byte(25'd4, 8'h01, ok);
    end_download();
    wait_done(start, ok);
    checks++; if (done_cksum !== 32'h000003FD) begin errors++; $display("FAIL checksum_done got=%h want=000003fd", done_cksum); end
    tick(5);
    checks++; if (checksum !== 32'h000003FD) begin errors++; $display("FAIL checksum_frozen got=%h want=000003fd", checksum); end
  endtask
`endif

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_data     = '0;
    bus.ioctl_wr       = 1'b0;
    m_waddr = '0;
    m_data  = '0;
    m_mask  = '0;
    #2;
    test_reset();
    tick(2);
    reset_n = 1'b1;
    tick(2);
    test_sequential();
    test_partial();
    test_stall();
    test_jump();
    test_random();
    test_empty_download();
    test_reset_mid();
`ifdef ROM_DOWNLOAD_CHECKSUM_EN
    test_checksum();
`endif
    checks++; if (we_err != 0) begin errors++; $display("FAIL we_tracks_req got=%0d want=0", we_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_download_writer.md
# rom_download_writer

Consumes the HPS ROM download byte stream (`ioctl_*`) and turns it into 32-bit word writes on the SDRAM controller's request/acknowledge port. Sits between `hps_io` and the `sdram` arbiter in the emu top level, active only while `ioctl_download` is high. It packs little-endian bytes into words, buffers up to two words, and back-pressures the HPS through `ioctl_wait` when the buffer is full. It pulses `done` once every byte has been committed to SDRAM.

## Interface
- `FIFO_DEPTH`, 2: words buffered between the assembler and the SDRAM port; power of two, at least 2.
- `clk` in 1: system clock (48 MHz `clk_sys`).
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: download window; high for the whole transfer.
- `ioctl_addr` in 25: byte address of the current byte.
- `ioctl_data` in 8: byte value.
- `ioctl_wr` in 1: one-cycle strobe, byte valid.
- `ioctl_wait` out 1: high means the HPS must not strobe again.
- `sdram_addr` out 23: 32-bit word address, equal to byte address [24:2].
- `sdram_data` out 32: write data.
- `sdram_we` out 1: high whenever `sdram_req` is high.
- `sdram_req` out 1: request level.
- `sdram_ack` in 1: one-cycle acceptance pulse.
- `busy` out 1: high while a word is assembling, buffered or in flight.
- `done` out 1: one-cycle pulse when the download is complete.
- `checksum` out 32: present only with the configuration macro (see Configuration).

## Operation
- **Reset values:** all outputs are 0. The FIFO is empty, the assembler is empty, and the state machine is IDLE.
- **Assembler:** holds a 32-bit word register, a 23-bit word address and a 4-bit byte-valid mask.
  - On `ioctl_wr`, the byte is written to lane `ioctl_addr[1:0]`, so lane 0 is bits [7:0].
- **Word completion:** a word is pushed to the FIFO when one of the following happens.
  - The mask reaches 4'hF.
  - A strobe arrives for a different word address. The partial word is pushed first and the new byte starts a fresh word in the same cycle.
  - `ioctl_download` falls while the mask is non-zero. This is a flush.
- **Padding:** lanes that never received a byte are written as 8'h00. The byte mask is not forwarded to SDRAM.
- **`ioctl_wait`:** high when the FIFO count is at least `FIFO_DEPTH`-1. This guarantees that one extra strobe arriving in the same cycle wait rises still fits.
- **Overflow:** a strobe into a full FIFO is dropped. That is a bench assertion failure, never expected in normal operation.
- **State machine, IDLE → REQ:** taken when the FIFO is non-empty. The head is loaded into `sdram_addr`/`sdram_data` and `sdram_req`/`sdram_we` are raised.
- **State machine, REQ:** address, data and request are held stable until `sdram_ack`.
  - On ack, the FIFO is popped.
  - If the FIFO still holds another word, the next head is loaded and `req` stays high, giving back-to-back requests.
  - Otherwise `req` drops and the machine returns to IDLE.
- **`sdram_valid`:** not used; writes complete on ack.
- **`done`:** pulsed for one cycle at the first cycle in which `ioctl_download` is low, the assembler is empty, the FIFO is empty and the state is IDLE, provided a download was active since the last `done`.
- **Downloads with no strobes:** still pulse `done`.
- **Re-raising `ioctl_download` before `done`:** allowed. Pending words keep draining.

## Timing
- Latency from the strobe completing a word to `sdram_req` high is 2 cycles: push, then load.
- With ack returning in the same cycle it is sampled, sustained throughput is one word every 2 cycles.
- `ioctl_wait` is registered; it reflects the FIFO count after the current cycle's push and pop.
- A push and a pop in the same cycle leave the count unchanged.
- Flush push happens the cycle after the falling edge of `ioctl_download` is detected (registered edge detect).
- Async reset mid-transfer clears everything immediately. Any in-flight `sdram_req` drops asynchronously, and the SDRAM controller must tolerate an abandoned request.

## Configuration
- `ROM_DOWNLOAD_CHECKSUM_EN`, when defined:
  - Adds the `checksum` port: a 32-bit wrapping sum of every accepted `ioctl_data` byte, zero-extended.
  - `checksum` is cleared on the rising edge of `ioctl_download` and frozen after `done`.
- When undefined, the port and its adder are absent and behaviour is otherwise identical.

## Structure
- Shared package `tecmo_pkg`, holding:
  - `WORD_WIDTH` = 32 and `BYTE_LANES` = 4.
  - A `sdram_word_t` struct containing `addr[22:0]` and `data[31:0]`.
  - A `writer_state_t` enum with IDLE and REQ.
- One sub-module, `word_fifo`: a synchronous FIFO of `sdram_word_t`, parameterised by depth, exposing count, push, pop and head outputs.

## Test plan
- **Sequential bytes.** Drive 8 sequential bytes 0x01..0x08 from address 0, with ack 1 cycle after req.
  - Two writes: word address 0 with data 32'h04030201, then word address 1 with 32'h08070605.
  - `done` pulses once.
- **Partial final word.** Drive 6 bytes 0xAA..0xAF from address 0x100, then drop download.
  - Write word address 0x40 with 32'hADACABAA.
  - Write word address 0x41 with 32'h0000AFAE after the flush.
- **Stalled ack.** Hold ack low for 50 cycles while strobing every cycle.
  - `ioctl_wait` rises with no byte lost.
  - After ack resumes, all words arrive in order with stable address and data during each stall.
- **Address jump.** Drive bytes at 0x10, 0x11, then 0x20.
  - Word 0x4 is flushed as 32'h0000XXYY before word 0x8 begins.
- **Reset mid-operation.** Assert `reset_n` low while `req` is high.
  - All outputs read 0 on the next sample, and a new download then works.
- **Checksum, macro defined.** Drive bytes 0xFF×4 plus 0x01.
  - `checksum` = 32'h000003FD at `done`.
